// File: rtl/ysyx_23060096_wbu.sv
// Writeback unit: arbitrates EXU/LSU results into one registered register-file write per cycle
// and tracks per-register pending writes. Optional bypass hit outputs: YSYX_23060096_WBU_BYPASS_EN.
module ysyx_23060096_wbu #(
    parameter int unsigned ADDR_WIDTH   = 5,
    parameter int unsigned DATA_WIDTH   = 32,
    parameter int unsigned STARVE_LIMIT = 4
) (
    input  logic                  clk,
    input  logic                  rstn,
    input  logic                  exu_valid,
    output logic                  exu_ready,
    input  logic [ADDR_WIDTH-1:0] exu_rd,
    input  logic [DATA_WIDTH-1:0] exu_data,
    input  logic                  lsu_valid,
    output logic                  lsu_ready,
    input  logic [ADDR_WIDTH-1:0] lsu_rd,
    input  logic [DATA_WIDTH-1:0] lsu_data,
    input  logic                  issue_valid,
    input  logic [ADDR_WIDTH-1:0] issue_rd,
    input  logic [ADDR_WIDTH-1:0] Ra,
    input  logic [ADDR_WIDTH-1:0] Rb,
    output logic                  busy_a,
    output logic                  busy_b,
    output logic                  hit_a,
    output logic                  hit_b,
    output logic                  w_en,
    output logic [ADDR_WIDTH-1:0] waddr,
    output logic [DATA_WIDTH-1:0] wdata,
    output logic [31:0]           wb_count
);

    localparam int unsigned NREG  = 1 << ADDR_WIDTH;
    localparam int unsigned CNT_W = 4;
    localparam logic [CNT_W-1:0] LIMIT = CNT_W'(STARVE_LIMIT);

    logic [CNT_W-1:0]      starve_cnt_q, starve_cnt_d;
    logic                  w_en_q, w_en_d;
    logic [ADDR_WIDTH-1:0] waddr_q, waddr_d;
    logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
    logic [31:0]           wb_count_q, wb_count_d;
    logic [NREG-1:0]       busy_q, busy_d;

    logic                  force_exu_c;
    logic                  lsu_hs_c, exu_hs_c, acc_c;
    logic [ADDR_WIDTH-1:0] acc_rd_c;
    logic [DATA_WIDTH-1:0] acc_data_c;

    // Arbitration: LSU first unless EXU has been held off STARVE_LIMIT cycles in a row
    always_comb begin
        force_exu_c = (starve_cnt_q == LIMIT);
        exu_ready   = !lsu_valid || force_exu_c;
        lsu_ready   = !(force_exu_c && exu_valid);
        lsu_hs_c    = lsu_valid && lsu_ready;
        exu_hs_c    = exu_valid && exu_ready;
        acc_c       = lsu_hs_c || exu_hs_c;
        acc_rd_c    = lsu_hs_c ? lsu_rd : exu_rd;
        acc_data_c  = lsu_hs_c ? lsu_data : exu_data;
    end

    // Next-state for starvation counter, write stage, counter and scoreboard
    always_comb begin
        starve_cnt_d = starve_cnt_q;
        w_en_d       = 1'b0;
        waddr_d      = waddr_q;
        wdata_d      = wdata_q;
        wb_count_d   = wb_count_q;
        busy_d       = busy_q;

        if (!exu_valid || exu_hs_c) begin
            starve_cnt_d = '0;
        end else if (starve_cnt_q != LIMIT) begin
            starve_cnt_d = starve_cnt_q + CNT_W'(1);
        end

        if (acc_c) begin
            w_en_d  = (acc_rd_c != '0);
            waddr_d = acc_rd_c;
            wdata_d = acc_data_c;
        end

        if (w_en_q) begin
            wb_count_d      = wb_count_q + 32'd1;
            busy_d[waddr_q] = 1'b0;
        end
        // Applied after the clear so a same-edge issue keeps the register busy
        if (issue_valid && (issue_rd != '0)) begin
            busy_d[issue_rd] = 1'b1;
        end
        busy_d[0] = 1'b0;
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            starve_cnt_q <= '0;
            w_en_q       <= 1'b0;
            waddr_q      <= '0;
            wdata_q      <= '0;
            wb_count_q   <= '0;
            busy_q       <= '0;
        end else begin
            starve_cnt_q <= starve_cnt_d;
            w_en_q       <= w_en_d;
            waddr_q      <= waddr_d;
            wdata_q      <= wdata_d;
            wb_count_q   <= wb_count_d;
            busy_q       <= busy_d;
        end
    end

    assign w_en     = w_en_q;
    assign waddr    = waddr_q;
    assign wdata    = wdata_q;
    assign wb_count = wb_count_q;

`ifdef YSYX_23060096_WBU_BYPASS_EN
    // A register written this cycle is readable from wdata, so it no longer stalls IDU
    always_comb begin
        hit_a  = w_en_q && (waddr_q == Ra) && (Ra != '0);
        hit_b  = w_en_q && (waddr_q == Rb) && (Rb != '0);
        busy_a = busy_q[Ra] && !hit_a;
        busy_b = busy_q[Rb] && !hit_b;
    end
`else
    always_comb begin
        hit_a  = 1'b0;
        hit_b  = 1'b0;
        busy_a = busy_q[Ra];
        busy_b = busy_q[Rb];
    end
`endif

endmodule

// File: tb/tb_ysyx_23060096_wbu.sv
// Directed self-checking bench for ysyx_23060096_wbu (default parameters).
module tb_ysyx_23060096_wbu;

    logic        clk;
    logic        rstn;
    logic        exu_valid, exu_ready;
    logic [4:0]  exu_rd;
    logic [31:0] exu_data;
    logic        lsu_valid, lsu_ready;
    logic [4:0]  lsu_rd;
    logic [31:0] lsu_data;
    logic        issue_valid;
    logic [4:0]  issue_rd;
    logic [4:0]  Ra, Rb;
    logic        busy_a, busy_b, hit_a, hit_b;
    logic        w_en;
    logic [4:0]  waddr;
    logic [31:0] wdata;
    logic [31:0] wb_count;

    int checks = 0;
    int fails  = 0;

    ysyx_23060096_wbu dut (
        .clk(clk), .rstn(rstn),
        .exu_valid(exu_valid), .exu_ready(exu_ready), .exu_rd(exu_rd), .exu_data(exu_data),
        .lsu_valid(lsu_valid), .lsu_ready(lsu_ready), .lsu_rd(lsu_rd), .lsu_data(lsu_data),
        .issue_valid(issue_valid), .issue_rd(issue_rd),
        .Ra(Ra), .Rb(Rb),
        .busy_a(busy_a), .busy_b(busy_b), .hit_a(hit_a), .hit_b(hit_b),
        .w_en(w_en), .waddr(waddr), .wdata(wdata), .wb_count(wb_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Inputs change 1 time unit after the rising edge; checks follow 1 unit later
    task automatic next();
        @(posedge clk);
        #1;
    endtask

    logic [31:0] exp_data;
    logic [4:0]  exp_addr;

    initial begin
        rstn = 1'b0;
        exu_valid = 1'b0; exu_rd = '0; exu_data = '0;
        lsu_valid = 1'b0; lsu_rd = '0; lsu_data = '0;
        issue_valid = 1'b0; issue_rd = '0;
        Ra = '0; Rb = '0;
        exp_data = '0; exp_addr = '0;
        next();
        next();
        #1;
        chk("rst_w_en", 32'(w_en), 32'd0);
        chk("rst_waddr", 32'(waddr), 32'd0);
        chk("rst_wdata", wdata, 32'd0);
        chk("rst_wb_count", wb_count, 32'd0);
        chk("rst_exu_ready", 32'(exu_ready), 32'd1);
        chk("rst_lsu_ready", 32'(lsu_ready), 32'd1);
        chk("rst_hit_a", 32'(hit_a), 32'd0);
        rstn = 1'b1;
        next();

        // Single EXU result
        exu_valid = 1'b1; exu_rd = 5'd5; exu_data = 32'h1234_5678;
        #1;
        chk("a_exu_ready", 32'(exu_ready), 32'd1);
        next();
        exu_valid = 1'b0;
        #1;
        chk("a_w_en", 32'(w_en), 32'd1);
        chk("a_waddr", 32'(waddr), 32'd5);
        chk("a_wdata", wdata, 32'h1234_5678);
        next();
        #1;
        chk("a_wb_count", wb_count, 32'd1);
        chk("a_w_en_off", 32'(w_en), 32'd0);

        // Both valid: LSU wins four cycles, EXU forced on the fifth, LSU resumes
        exu_valid = 1'b1; exu_rd = 5'd9; exu_data = 32'h99;
        lsu_valid = 1'b1; lsu_rd = 5'd10;
        for (int k = 1; k <= 6; k++) begin
            lsu_data = 32'h100 + 32'((k <= 5) ? k : 5);
            if (k == 6) exu_valid = 1'b0;
            #1;
            chk($sformatf("b_exu_ready_%0d", k), 32'(exu_ready), 32'((k == 5) ? 1 : 0));
            chk($sformatf("b_lsu_ready_%0d", k), 32'(lsu_ready), 32'((k == 5) ? 0 : 1));
            if (k >= 2) begin
                chk($sformatf("b_waddr_%0d", k), 32'(waddr), 32'(exp_addr));
                chk($sformatf("b_wdata_%0d", k), wdata, exp_data);
            end
            exp_addr = (k == 5) ? 5'd9 : 5'd10;
            exp_data = (k == 5) ? 32'h99 : lsu_data;
            next();
        end
        lsu_valid = 1'b0;
        #1;
        chk("b_last_w_en", 32'(w_en), 32'd1);
        chk("b_last_wdata", wdata, 32'h105);
        chk("b_wb_count_mid", wb_count, 32'd6);
        next();
        #1;
        chk("b_wb_count", wb_count, 32'd7);

        // rd=0 result: handshake but no write
        exu_valid = 1'b1; exu_rd = 5'd0; exu_data = 32'hFFFF_FFFF;
        #1;
        chk("c_exu_ready", 32'(exu_ready), 32'd1);
        next();
        exu_valid = 1'b0;
        #1;
        chk("c_w_en", 32'(w_en), 32'd0);
        next();
        #1;
        chk("c_wb_count", wb_count, 32'd7);

        // Scoreboard set and clear through an LSU write
        Ra = 5'd7; issue_valid = 1'b1; issue_rd = 5'd7;
        #1;
        chk("d_busy_pre", 32'(busy_a), 32'd0);
        next();
        issue_valid = 1'b0;
        lsu_valid = 1'b1; lsu_rd = 5'd7; lsu_data = 32'hA5;
        #1;
        chk("d_busy_set", 32'(busy_a), 32'd1);
        next();
        lsu_valid = 1'b0;
        #1;
        chk("d_w_en", 32'(w_en), 32'd1);
        chk("d_wdata", wdata, 32'hA5);
`ifdef YSYX_23060096_WBU_BYPASS_EN
        chk("d_busy_wcyc", 32'(busy_a), 32'd0);
        chk("d_hit_wcyc", 32'(hit_a), 32'd1);
`else
        chk("d_busy_wcyc", 32'(busy_a), 32'd1);
        chk("d_hit_wcyc", 32'(hit_a), 32'd0);
`endif
        next();
        #1;
        chk("d_busy_clr", 32'(busy_a), 32'd0);
        chk("d_hit_clr", 32'(hit_a), 32'd0);

        // Same-edge set and clear of register 3: set wins
        Rb = 5'd3; issue_valid = 1'b1; issue_rd = 5'd3;
        lsu_valid = 1'b1; lsu_rd = 5'd3; lsu_data = 32'h33;
        next();
        lsu_valid = 1'b0;
        #1;
        chk("e_w_en", 32'(w_en), 32'd1);
        chk("e_waddr", 32'(waddr), 32'd3);
`ifdef YSYX_23060096_WBU_BYPASS_EN
        chk("e_busy_wcyc", 32'(busy_b), 32'd0);
`else
        chk("e_busy_wcyc", 32'(busy_b), 32'd1);
`endif
        next();
        issue_valid = 1'b0;
        #1;
        chk("e_busy_kept", 32'(busy_b), 32'd1);
        chk("e_wb_count", wb_count, 32'd9);

        // Reset during an LSU acceptance discards it and clears all state
        Ra = 5'd3;
        lsu_valid = 1'b1; lsu_rd = 5'd12; lsu_data = 32'hCC;
        rstn = 1'b0;
        #1;
        chk("f_busy_before", 32'(busy_a), 32'd1);
        next();
        rstn = 1'b1; lsu_valid = 1'b0;
        #1;
        chk("f_w_en", 32'(w_en), 32'd0);
        chk("f_waddr", 32'(waddr), 32'd0);
        chk("f_wb_count", wb_count, 32'd0);
        chk("f_busy_a", 32'(busy_a), 32'd0);
        chk("f_busy_b", 32'(busy_b), 32'd0);
        next();
        #1;
        chk("f_w_en_after", 32'(w_en), 32'd0);

        $display("%0d/%0d checks passed", checks - fails, checks);
        $finish;
    end

endmodule
